// File: rtl/openhmc_rf_master_pkg.sv
// Shared types for the openHMC register-file access initiator.
// Default widths match the controller RF port.
package openhmc_rf_master_pkg;

    localparam int RF_WWIDTH = 64;
    localparam int RF_RWIDTH = 64;
    localparam int RF_AWIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } rf_mst_state_t;

    typedef struct packed {
        logic                 write;
        logic [RF_AWIDTH-1:0] address;
        logic [RF_WWIDTH-1:0] wdata;
    } rf_req_t;

    typedef struct packed {
        logic [RF_RWIDTH-1:0] rdata;
        logic                 invalid_address;
        logic                 timeout;
        logic                 was_write;
    } rf_resp_t;

endpackage

// File: rtl/openhmc_rf_master.sv
// Single-outstanding RF access initiator: request channel in,
// RF read/write strobes out, response channel back with timeout.
module openhmc_rf_master
    import openhmc_rf_master_pkg::*;
#(
    parameter int HMC_RF_WWIDTH = RF_WWIDTH,
    parameter int HMC_RF_RWIDTH = RF_RWIDTH,
    parameter int HMC_RF_AWIDTH = RF_AWIDTH,
    parameter int TIMEOUT_LOG   = 8
) (
    input  logic                     clk_hmc,
    input  logic                     res_n_hmc,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [HMC_RF_AWIDTH-1:0] req_address,
    input  logic [HMC_RF_WWIDTH-1:0] req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [HMC_RF_RWIDTH-1:0] resp_rdata,
    output logic                     resp_invalid_address,
    output logic                     resp_timeout,
    output logic                     resp_was_write,
    output logic [HMC_RF_AWIDTH-1:0] rf_address,
    output logic                     rf_read_en,
    output logic                     rf_write_en,
    output logic [HMC_RF_WWIDTH-1:0] rf_write_data,
    input  logic [HMC_RF_RWIDTH-1:0] rf_read_data,
    input  logic                     rf_invalid_address,
    input  logic                     rf_access_complete,
    output logic                     busy
);

    rf_mst_state_t          state;
    rf_mst_state_t          state_nxt;
    rf_req_t                req_q;
    rf_resp_t               resp_q;
    rf_resp_t               resp_nxt;
    logic [TIMEOUT_LOG-1:0] cnt;
    logic                   cnt_term;
    logic                   load_req;
    logic                   load_resp;
    logic                   cnt_clr;
    logic                   cnt_inc;

    assign cnt_term = (cnt == {TIMEOUT_LOG{1'b1}});

    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Completion is checked before the terminal count so it wins a tie.
    always_comb begin
        state_nxt = state;
        load_req  = 1'b0;
        load_resp = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        resp_nxt  = resp_q;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = ACCESS;
                    load_req  = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
            ACCESS: begin
                if (rf_access_complete) begin
                    state_nxt                = RESP;
                    load_resp                = 1'b1;
                    resp_nxt.rdata           = req_q.write ? '0
                                             : RF_RWIDTH'(rf_read_data);
                    resp_nxt.invalid_address = rf_invalid_address;
                    resp_nxt.timeout         = 1'b0;
                    resp_nxt.was_write       = req_q.write;
                end else if (cnt_term) begin
                    state_nxt                = RESP;
                    load_resp                = 1'b1;
                    resp_nxt.rdata           = '0;
                    resp_nxt.invalid_address = 1'b0;
                    resp_nxt.timeout         = 1'b1;
                    resp_nxt.was_write       = req_q.write;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            req_q <= '0;
        end else if (load_req) begin
            req_q.write   <= req_write;
            req_q.address <= RF_AWIDTH'(req_address);
            req_q.wdata   <= RF_WWIDTH'(req_wdata);
        end
    end

    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            resp_q <= '0;
        end else if (load_resp) begin
            resp_q <= resp_nxt;
        end
    end

    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign req_ready            = (state == IDLE);
    assign busy                 = (state != IDLE);
    assign rf_read_en           = (state == ACCESS) && !req_q.write;
    assign rf_write_en          = (state == ACCESS) && req_q.write;
    assign rf_address           = req_q.address[HMC_RF_AWIDTH-1:0];
    assign rf_write_data        = req_q.wdata[HMC_RF_WWIDTH-1:0];
    assign resp_valid           = (state == RESP);
    assign resp_rdata           = resp_q.rdata[HMC_RF_RWIDTH-1:0];
    assign resp_invalid_address = resp_q.invalid_address;
    assign resp_timeout         = resp_q.timeout;
    assign resp_was_write       = resp_q.was_write;

endmodule

// File: tb/tb_openhmc_rf_master.sv
// Directed bench for openhmc_rf_master, built with TIMEOUT_LOG = 4.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_openhmc_rf_master;

    logic        clk_hmc = 1'b0;
    logic        res_n_hmc;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_address;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_invalid_address;
    logic        resp_timeout;
    logic        resp_was_write;
    logic [3:0]  rf_address;
    logic        rf_read_en;
    logic        rf_write_en;
    logic [63:0] rf_write_data;
    logic [63:0] rf_read_data;
    logic        rf_invalid_address;
    logic        rf_access_complete;
    logic        busy;

    int checks = 0;
    int errors = 0;

    openhmc_rf_master #(
        .HMC_RF_WWIDTH(64),
        .HMC_RF_RWIDTH(64),
        .HMC_RF_AWIDTH(4),
        .TIMEOUT_LOG(4)
    ) dut (
        .clk_hmc(clk_hmc),
        .res_n_hmc(res_n_hmc),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_address(req_address),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_invalid_address(resp_invalid_address),
        .resp_timeout(resp_timeout),
        .resp_was_write(resp_was_write),
        .rf_address(rf_address),
        .rf_read_en(rf_read_en),
        .rf_write_en(rf_write_en),
        .rf_write_data(rf_write_data),
        .rf_read_data(rf_read_data),
        .rf_invalid_address(rf_invalid_address),
        .rf_access_complete(rf_access_complete),
        .busy(busy)
    );

    always #5 clk_hmc = ~clk_hmc;

    task automatic tick();
        @(posedge clk_hmc);
        #1;
    endtask

    // Presents one command for a single cycle; DUT is in ACCESS on return.
    task automatic issue(input logic w, input logic [3:0] a, input logic [63:0] d);
        req_valid   = 1'b1;
        req_write   = w;
        req_address = a;
        req_wdata   = d;
        tick();
        req_valid   = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl got rdy=%b vld=%b busy=%b exp 1/0/0", req_ready, resp_valid, busy);
        end
        checks++;
        if (rf_read_en !== 1'b0 || rf_write_en !== 1'b0 || rf_address !== 4'h0 || rf_write_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_rf got re=%b we=%b a=%h d=%h exp all 0", rf_read_en, rf_write_en, rf_address, rf_write_data);
        end
        checks++;
        if (resp_rdata !== 64'h0 || resp_timeout !== 1'b0 || resp_invalid_address !== 1'b0 || resp_was_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp got rd=%h to=%b ia=%b ww=%b exp all 0", resp_rdata, resp_timeout, resp_invalid_address, resp_was_write);
        end
    endtask

    task automatic test_write();
        rf_read_data = 64'hFFFF_0000_FFFF_0000;
        issue(1'b1, 4'h2, 64'hDEAD_BEEF);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (rf_write_en !== 1'b1 || rf_read_en !== 1'b0 || rf_address !== 4'h2 || rf_write_data !== 64'hDEAD_BEEF) begin
                errors++;
                $display("FAIL wr_access k=%0d got we=%b re=%b a=%h d=%h exp 1/0/2/deadbeef", k, rf_write_en, rf_read_en, rf_address, rf_write_data);
            end
            if (k == 4) rf_access_complete = 1'b1;
            tick();
        end
        rf_access_complete = 1'b0;
        checks++;
        if (rf_write_en !== 1'b0 || resp_valid !== 1'b1 || resp_was_write !== 1'b1 || resp_rdata !== 64'h0 || resp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp got we=%b vld=%b ww=%b rd=%h to=%b exp 0/1/1/0/0", rf_write_en, resp_valid, resp_was_write, resp_rdata, resp_timeout);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_done got vld=%b rdy=%b busy=%b exp 0/1/0", resp_valid, req_ready, busy);
        end
    endtask

    task automatic test_read_fast();
        resp_ready = 1'b1;
        issue(1'b0, 4'h5, 64'h0);
        checks++;
        if (rf_read_en !== 1'b1 || rf_write_en !== 1'b0 || rf_address !== 4'h5 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rd_access got re=%b we=%b a=%h rdy=%b exp 1/0/5/0", rf_read_en, rf_write_en, rf_address, req_ready);
        end
        rf_access_complete = 1'b1;
        rf_read_data       = 64'h1234;
        tick();
        rf_access_complete = 1'b0;
        rf_read_data       = 64'h0;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 64'h1234 || rf_read_en !== 1'b0 || resp_was_write !== 1'b0) begin
            errors++;
            $display("FAIL rd_resp got vld=%b rd=%h re=%b ww=%b exp 1/1234/0/0", resp_valid, resp_rdata, rf_read_en, resp_was_write);
        end
        tick();
        resp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_turnaround got rdy=%b vld=%b exp 1/0", req_ready, resp_valid);
        end
    endtask

    task automatic test_invalid_address();
        issue(1'b0, 4'h7, 64'h0);
        rf_access_complete = 1'b1;
        rf_invalid_address = 1'b1;
        rf_read_data       = 64'hAB;
        tick();
        rf_access_complete = 1'b0;
        rf_invalid_address = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_invalid_address !== 1'b1 || resp_timeout !== 1'b0 || resp_rdata !== 64'hAB) begin
            errors++;
            $display("FAIL inv_addr got vld=%b ia=%b to=%b rd=%h exp 1/1/0/ab", resp_valid, resp_invalid_address, resp_timeout, resp_rdata);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int hi;
        rf_invalid_address = 1'b1;
        rf_read_data       = 64'h99;
        issue(1'b0, 4'h3, 64'h0);
        hi = 0;
        for (int k = 1; k <= 16; k++) begin
            if (rf_read_en === 1'b1) hi++;
            tick();
        end
        checks++;
        if (hi !== 16 || rf_read_en !== 1'b0) begin
            errors++;
            $display("FAIL to_enable got high=%0d re_after=%b exp 16/0", hi, rf_read_en);
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_timeout !== 1'b1 || resp_rdata !== 64'h0 || resp_invalid_address !== 1'b0) begin
            errors++;
            $display("FAIL to_resp got vld=%b to=%b rd=%h ia=%b exp 1/1/0/0", resp_valid, resp_timeout, resp_rdata, resp_invalid_address);
        end
        rf_invalid_address = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        issue(1'b0, 4'h4, 64'h0);
        for (int k = 1; k <= 16; k++) begin
            if (k == 16) begin
                rf_access_complete = 1'b1;
                rf_read_data       = 64'h55;
            end
            tick();
        end
        rf_access_complete = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_timeout !== 1'b0 || resp_rdata !== 64'h55) begin
            errors++;
            $display("FAIL to_tie got vld=%b to=%b rd=%h exp 1/0/55", resp_valid, resp_timeout, resp_rdata);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int bad;
        rf_access_complete = 1'b1;
        tick();
        rf_access_complete = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_complete got rdy=%b vld=%b busy=%b exp 1/0/0", req_ready, resp_valid, busy);
        end
        issue(1'b0, 4'hC, 64'h0);
        rf_access_complete = 1'b1;
        rf_read_data       = 64'hCAFE;
        tick();
        rf_access_complete = 1'b0;
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_address = 4'h9;
        req_wdata   = 64'h77;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            rf_access_complete = (k == 4);
            rf_read_data       = 64'h1111 * k;
            if (resp_valid !== 1'b1 || resp_rdata !== 64'hCAFE || resp_was_write !== 1'b0 || req_ready !== 1'b0 || rf_write_en !== 1'b0 || rf_read_en !== 1'b0) bad++;
            tick();
        end
        rf_access_complete = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_hold got bad_cycles=%0d exp 0 (rd=%h rdy=%b)", bad, resp_rdata, req_ready);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || rf_write_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_handshake got rdy=%b vld=%b we=%b exp 1/0/0", req_ready, resp_valid, rf_write_en);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (rf_write_en !== 1'b1 || rf_address !== 4'h9 || rf_write_data !== 64'h77) begin
            errors++;
            $display("FAIL bp_next got we=%b a=%h d=%h exp 1/9/77", rf_write_en, rf_address, rf_write_data);
        end
        rf_access_complete = 1'b1;
        tick();
        rf_access_complete = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        issue(1'b1, 4'hA, 64'h5A5A);
        tick();
        #2;
        res_n_hmc = 1'b0;
        #1;
        checks++;
        if (rf_write_en !== 1'b0 || rf_read_en !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got we=%b re=%b vld=%b busy=%b exp 0/0/0/0", rf_write_en, rf_read_en, resp_valid, busy);
        end
        #2;
        res_n_hmc = 1'b1;
        tick();
        tick();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || rf_write_en !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got rdy=%b vld=%b we=%b exp 1/0/0", req_ready, resp_valid, rf_write_en);
        end
    endtask

    task automatic test_random();
        logic        w;
        logic [3:0]  a;
        logic [63:0] d;
        logic [63:0] rd;
        int          dly;
        int          stall;
        for (int t = 0; t < 30; t++) begin
            w     = 1'($urandom_range(0, 1));
            a     = 4'($urandom_range(0, 15));
            d     = {$urandom, $urandom};
            rd    = {$urandom, $urandom};
            dly   = $urandom_range(0, 4);
            stall = $urandom_range(0, 3);
            issue(w, a, d);
            for (int k = 0; k <= dly; k++) begin
                checks++;
                if ((rf_read_en & rf_write_en) !== 1'b0 || rf_write_en !== w || rf_read_en !== !w || rf_address !== a || rf_write_data !== d) begin
                    errors++;
                    $display("FAIL rnd_access t=%0d k=%0d got we=%b re=%b a=%h exp we=%b a=%h", t, k, rf_write_en, rf_read_en, rf_address, w, a);
                end
                if (k == dly) begin
                    rf_access_complete = 1'b1;
                    rf_read_data       = rd;
                end
                tick();
            end
            rf_access_complete = 1'b0;
            for (int s = 0; s <= stall; s++) begin
                if (s == stall) resp_ready = 1'b1;
                checks++;
                if (resp_valid !== 1'b1 || resp_rdata !== (w ? 64'h0 : rd) || resp_was_write !== w || resp_timeout !== 1'b0 || (rf_read_en | rf_write_en) !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_resp t=%0d s=%0d got vld=%b rd=%h ww=%b exp rd=%h ww=%b", t, s, resp_valid, resp_rdata, resp_was_write, (w ? 64'h0 : rd), w);
                end
                tick();
            end
            resp_ready = 1'b0;
        end
    endtask

    initial begin
        res_n_hmc          = 1'b0;
        req_valid          = 1'b0;
        req_write          = 1'b0;
        req_address        = 4'h0;
        req_wdata          = 64'h0;
        resp_ready         = 1'b0;
        rf_read_data       = 64'h0;
        rf_invalid_address = 1'b0;
        rf_access_complete = 1'b0;
        #23;
        test_reset();
        res_n_hmc = 1'b1;
        tick();
        test_write();
        test_read_fast();
        test_invalid_address();
        test_timeout();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
